rtc_uart_tx: RTL and testbench

RTC_UART_TX -- requirements
Module: rtc_uart_tx

---
 rtl/rtc_uart_tx_pkg.sv | 57 +++++
 rtl/rtc_uart_tx_byte.sv | 102 ++++++++++
 rtl/rtc_uart_tx.sv | 83 ++++++++
 tb/tb_rtc_uart_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_uart_tx_pkg.sv
// Shared types and constants for the RTC time-message UART transmitter.
// Holds the ASCII constants, serializer state encoding and character mapping.
package rtc_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [3:0] LAST_CHAR = 4'd9;

    typedef struct packed {
        logic [3:0] hrm;
        logic [3:0] hrl;
        logic [3:0] minm;
        logic [3:0] minl;
        logic [3:0] secm;
        logic [3:0] secl;
    } rtc_time_t;

    // Non-BCD digit values are shown as '?' so a bad RTC is visible.
    function automatic logic [7:0] enc_digit(input logic [3:0] d);
        if (d <= 4'd9)
            return ASCII_ZERO + {4'h0, d};
        else
            return ASCII_QMARK;
    endfunction

    // Character idx of the "hh:mm:ss\r\n" message.
    function automatic logic [7:0] char_at(input logic [3:0] idx,
                                           input rtc_time_t t);
        logic [7:0] c;
        c = ASCII_LF;
        case (idx)
            4'd0:    c = enc_digit(t.hrm);
            4'd1:    c = enc_digit(t.hrl);
            4'd2:    c = ASCII_COLON;
            4'd3:    c = enc_digit(t.minm);
            4'd4:    c = enc_digit(t.minl);
            4'd5:    c = ASCII_COLON;
            4'd6:    c = enc_digit(t.secm);
            4'd7:    c = enc_digit(t.secl);
            4'd8:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_uart_tx_byte.sv
// 8N1 byte serializer with a load/ready handshake.
// ready is high in idle and on the last cycle of a stop bit so bytes chain gap-free.
module uart_tx_byte
    import rtc_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic [7:0]    shreg;
    logic [7:0]    sh_n;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    assign ready   = (state == ST_IDLE) ||
                     ((state == ST_STOP) && bit_end);

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
        end
    end

    // Next-state logic: bit timing is a count enable, never a derived clock.
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        sh_n    = shreg;
        cnt_n   = bit_end ? '0 : cnt + CW'(1);
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (load) begin
                    state_n = ST_START;
                    sh_n    = data;
                    bit_n   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7)
                        state_n = ST_STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (load) begin
                        state_n = ST_START;
                        sh_n    = data;
                        bit_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Line level follows the current frame position; idle and stop are high.
    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[bit_idx];
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/rtc_uart_tx.sv
// Sends "hh:mm:ss\r\n" from a snapshot of the RTC digits on each accepted start.
// The serializer does the framing; this level picks characters and flags.
module rtc_uart_tx
    import rtc_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hrm,
    input  logic [3:0] hrl,
    input  logic [3:0] minm,
    input  logic [3:0] minl,
    input  logic [3:0] secm,
    input  logic [3:0] secl,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    rtc_time_t  snap;
    rtc_time_t  live;
    logic [3:0] char_idx;
    logic       busy_q;
    logic       done_q;
    logic       byte_ready;
    logic       accept;
    logic       more;
    logic       finish;
    logic       load;
    logic [7:0] data;

    assign live   = '{hrm: hrm, hrl: hrl, minm: minm,
                      minl: minl, secm: secm, secl: secl};
    assign accept = start && !busy_q;
    assign more   = busy_q && byte_ready && (char_idx != LAST_CHAR);
    assign finish = busy_q && byte_ready && (char_idx == LAST_CHAR);
    assign load   = accept || more;
    assign busy   = busy_q;
    assign done   = done_q;

    // The first character comes straight from the live digits on the accept edge.
    always_comb begin
        data = char_at(char_idx + 4'd1, snap);
        if (accept)
            data = enc_digit(hrm);
    end

    // Message sequencing: snapshot, character index, busy and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap     <= '0;
            char_idx <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                snap     <= live;
                char_idx <= '0;
                busy_q   <= 1'b1;
            end else if (more) begin
                char_idx <= char_idx + 4'd1;
            end else if (finish) begin
                char_idx <= '0;
                busy_q   <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
        .tx   (tx),
        .ready(byte_ready)
    );

endmodule

// File: tb/tb_rtc_uart_tx.sv
// Directed bench for rtc_uart_tx at four clocks per bit.
// Decodes the line at mid-bit and checks busy/done timing around each message.
module tb_rtc_uart_tx;

    localparam int CPB = 4;
    localparam int MSG = 100 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] hrm = 4'd2;
    logic [3:0] hrl = 4'd3;
    logic [3:0] minm = 4'd5;
    logic [3:0] minl = 4'd9;
    logic [3:0] secm = 4'd5;
    logic [3:0] secl = 4'd9;
    logic       start = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors = 0;

    logic [7:0] exp_2359 [10] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39,
                                  8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
    logic [7:0] exp_q000 [10] = '{8'h3F, 8'h30, 8'h3A, 8'h30, 8'h30,
                                  8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};

    logic [7:0] msg [10];
    int nbusy;
    int ndone;
    int nframe;

    rtc_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .hrm  (hrm),
        .hrl  (hrl),
        .minm (minm),
        .minl (minl),
        .secm (secm),
        .secl (secl),
        .start(start),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] e, input logic [3:0] f);
        hrm = a; hrl = b; minm = c; minl = d; secm = e; secl = f;
    endtask

    // Called just after the accept edge; returns in the cycle after the last stop bit.
    task automatic run_msg(input int chg_at, input int pulse_at,
                           input logic hold);
        int k;
        int b;
        nbusy = 0;
        ndone = 0;
        nframe = 0;
        for (int i = 0; i < 10; i++) msg[i] = 8'h00;
        for (int c = 0; c < MSG; c++) begin
            if (c == chg_at) set_time(0, 0, 0, 0, 0, 0);
            start = hold || (c == pulse_at);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) ndone++;
            if ((c % CPB) == CPB / 2) begin
                k = c / (10 * CPB);
                b = (c % (10 * CPB)) / CPB;
                if (b == 0) begin
                    if (tx !== 1'b0) nframe++;
                end else if (b == 9) begin
                    if (tx !== 1'b1) nframe++;
                end else begin
                    msg[k][b-1] = tx;
                end
            end
            tick();
        end
    endtask

    task automatic chk_msg(input string tag, input logic [7:0] e [10]);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_char%0d", tag, i), {24'h0, msg[i]},
                {24'h0, e[i]});
        chk({tag, "_frame"}, nframe, 0);
        chk({tag, "_busy_cycles"}, nbusy, MSG);
        chk({tag, "_done_inside"}, ndone, 0);
        chk({tag, "_done_pulse"}, {31'h0, done}, 1);
        chk({tag, "_busy_end"}, {31'h0, busy}, 0);
        chk({tag, "_tx_end"}, {31'h0, tx}, 1);
    endtask

    initial begin
        // Reset held with start high: nothing may be accepted.
        start = 1'b1;
        repeat (3) tick();
        chk("rst_tx", {31'h0, tx}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);

        // First edge with rst high accepts.
        rst = 1'b1;
        tick();
        chk("acc_busy", {31'h0, busy}, 1);
        chk("acc_tx", {31'h0, tx}, 0);
        start = 1'b0;
        run_msg(-1, -1, 1'b0);
        chk_msg("m2359", exp_2359);
        tick();
        chk("m2359_done_clear", {31'h0, done}, 0);

        // Digits change one cycle after accept; snapshot must hold.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_msg(0, -1, 1'b0);
        chk_msg("snap", exp_2359);
        tick();
        set_time(2, 3, 5, 9, 5, 9);

        // Start pulse while busy is dropped, not queued.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_msg(-1, 50, 1'b0);
        chk_msg("ign", exp_2359);
        nbusy = 0;
        repeat (2 * CPB) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) nbusy++;
        end
        chk("ign_no_second", nbusy, 0);

        // Start held high: back-to-back messages, one done each.
        start = 1'b1;
        tick();
        run_msg(-1, -1, 1'b1);
        chk_msg("b2b1", exp_2359);
        tick();
        chk("b2b_restart_busy", {31'h0, busy}, 1);
        chk("b2b_restart_tx", {31'h0, tx}, 0);
        chk("b2b_restart_done", {31'h0, done}, 0);
        run_msg(-1, -1, 1'b1);
        chk_msg("b2b2", exp_2359);
        start = 1'b0;
        tick();
        chk("b2b_stop_busy", {31'h0, busy}, 0);

        // Invalid hour digit shows as '?'.
        set_time(4'hA, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_msg(-1, -1, 1'b0);
        chk_msg("qmark", exp_q000);
        tick();

        // Reset mid-message at cycle 150 aborts cleanly.
        set_time(2, 3, 5, 9, 5, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        chk("abort_pre_tx", {31'h0, tx}, 0);
        rst = 1'b0;
        tick();
        chk("abort_tx", {31'h0, tx}, 1);
        chk("abort_busy", {31'h0, busy}, 0);
        rst = 1'b1;
        ndone = 0;
        repeat (MSG) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) ndone++;
        end
        chk("abort_quiet", ndone, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_msg(-1, -1, 1'b0);
        chk_msg("after_abort", exp_2359);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
